// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
// Both the top and the load-use comparator import this package.
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W_DEFAULT = 5;
  localparam int CNT_W_DEFAULT      = 16;
  localparam int MULDIV_MAX_DEFAULT = 40;

  // Architectural x0: writes to it are discarded, so it never creates a hazard
  localparam int unsigned X0_ADDR = 0;

  typedef enum logic [0:0] {
    ST_RUN         = 1'b0,
    ST_MULDIV_WAIT = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use comparator: flags an ID instruction that reads the rd of a load
// currently in EX.
module load_use_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_write_addr,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write_en,
  output logic                  hazard
);

  logic rd_live_s;
  logic rs1_hit_s;
  logic rs2_hit_s;

  assign rd_live_s = ex_mem_read && ex_reg_write_en &&
                     (ex_write_addr != REG_ADDR_W'(X0_ADDR));
  assign rs1_hit_s = id_uses_rs1 && (id_rs1 == ex_write_addr);
  assign rs2_hit_s = id_uses_rs2 && (id_rs2 == ex_write_addr);
  assign hazard    = rd_live_s && (rs1_hit_s || rs2_hit_s);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: per-stage enables
// and bubbles, MUL/DIV handshake with timeout, saturating perf counters.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
  parameter int CNT_W      = CNT_W_DEFAULT,
  parameter int MULDIV_MAX = MULDIV_MAX_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  imem_busywait,
  input  logic                  dmem_busywait,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_write_addr,
  input  logic                  ex_mem_read,
  input  logic                  ex_reg_write_en,
  input  logic                  ex_branch_taken,
  input  logic                  ex_is_muldiv,
  input  logic                  muldiv_done,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  idex_en,
  output logic                  idex_flush,
  output logic                  exmem_en,
  output logic                  exmem_flush,
  output logic                  memwb_en,
  output logic                  muldiv_start,
  output logic                  muldiv_err,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam int              TMR_W    = $clog2(MULDIV_MAX + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MULDIV_MAX - 1);
  localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};

  ctrl_state_e      state_r, state_nxt_s;
  logic [TMR_W-1:0] timer_r, timer_nxt_s;
  logic             done_seen_r, done_seen_nxt_s;
  logic             err_r;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  logic busy_s, hazard_s, branch_evt_s, timeout_s;
  logic pc_en_s, ifid_en_s, ifid_flush_s, idex_en_s, idex_flush_s;
  logic exmem_en_s, exmem_flush_s, memwb_en_s, start_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use (
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_uses_rs1     (id_uses_rs1),
    .id_uses_rs2     (id_uses_rs2),
    .ex_write_addr   (ex_write_addr),
    .ex_mem_read     (ex_mem_read),
    .ex_reg_write_en (ex_reg_write_en),
    .hazard          (hazard_s)
  );

  assign busy_s = imem_busywait || dmem_busywait;

  // Next-state and stage-control decode for both controller states
  always_comb begin
    state_nxt_s     = state_r;
    timer_nxt_s     = timer_r;
    done_seen_nxt_s = done_seen_r;
    branch_evt_s    = 1'b0;
    timeout_s       = 1'b0;
    pc_en_s         = 1'b0;
    ifid_en_s       = 1'b0;
    ifid_flush_s    = 1'b0;
    idex_en_s       = 1'b0;
    idex_flush_s    = 1'b0;
    exmem_en_s      = 1'b0;
    exmem_flush_s   = 1'b0;
    memwb_en_s      = 1'b0;
    start_s         = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (busy_s) begin
          pc_en_s = 1'b0;
        end else if (ex_branch_taken) begin
          {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s} = 5'b11111;
          ifid_flush_s = 1'b1;
          idex_flush_s = 1'b1;
          branch_evt_s = 1'b1;
        end else if (ex_is_muldiv) begin
          // Hold the M op in EX; MEM/WB keeps draining the older instruction
          start_s         = 1'b1;
          memwb_en_s      = 1'b1;
          timer_nxt_s     = TMR_ZERO;
          done_seen_nxt_s = 1'b0;
          state_nxt_s     = ST_MULDIV_WAIT;
        end else if (hazard_s) begin
          idex_en_s    = 1'b1;
          idex_flush_s = 1'b1;
          exmem_en_s   = 1'b1;
          memwb_en_s   = 1'b1;
        end else begin
          {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s} = 5'b11111;
        end
      end
      ST_MULDIV_WAIT: begin
        timer_nxt_s = timer_r + TMR_W'(1);
        if (busy_s) begin
          // A result arriving under busywait is remembered until memory frees up
          if (muldiv_done) begin
            done_seen_nxt_s = 1'b1;
          end else begin
            done_seen_nxt_s = done_seen_r;
          end
        end else if (muldiv_done || done_seen_r) begin
          {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s} = 5'b11111;
          done_seen_nxt_s = 1'b0;
          state_nxt_s     = ST_RUN;
        end else if (timer_r == TMR_LAST) begin
          {pc_en_s, ifid_en_s, idex_en_s, exmem_en_s, memwb_en_s} = 5'b11111;
          idex_flush_s = 1'b1;
          timeout_s    = 1'b1;
          state_nxt_s  = ST_RUN;
        end else begin
          memwb_en_s    = (timer_r == TMR_ZERO);
          exmem_flush_s = (timer_r == TMR_ZERO);
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
      end
    endcase
  end

  // State, wait timer, sticky error and saturating performance counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_RUN;
      timer_r     <= TMR_ZERO;
      done_seen_r <= 1'b0;
      err_r       <= 1'b0;
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      timer_r     <= timer_nxt_s;
      done_seen_r <= done_seen_nxt_s;
      err_r       <= err_r || timeout_s;
      if (!pc_en_s) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (branch_evt_s) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  // Strobes are forced low for as long as reset is held
  assign pc_en        = reset && pc_en_s;
  assign ifid_en      = reset && ifid_en_s;
  assign ifid_flush   = reset && ifid_flush_s;
  assign idex_en      = reset && idex_en_s;
  assign idex_flush   = reset && idex_flush_s;
  assign exmem_en     = reset && exmem_en_s;
  assign exmem_flush  = reset && exmem_flush_s;
  assign memwb_en     = reset && memwb_en_s;
  assign muldiv_start = reset && start_s;
  assign muldiv_err   = reset && (err_r || timeout_s);
  assign stall_cnt    = stall_cnt_r;
  assign flush_cnt    = flush_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench: the driver queues hand-computed expectations per
// cycle, a monitor pops and compares them mid-cycle.
module tb_pipeline_hazard_ctrl;

  // {pc, ifid, ifid_fl, idex, idex_fl, exmem, exmem_fl, memwb, start, err}
  localparam logic [9:0] O_FREEZE  = 10'b0000000000;
  localparam logic [9:0] O_ALL     = 10'b1101010100;
  localparam logic [9:0] O_ALL_E   = 10'b1101010101;
  localparam logic [9:0] O_BRANCH  = 10'b1111110100;
  localparam logic [9:0] O_BR_E    = 10'b1111110101;
  localparam logic [9:0] O_LOADUSE = 10'b0001110100;
  localparam logic [9:0] O_MSTART  = 10'b0000000110;
  localparam logic [9:0] O_MSTRT_E = 10'b0000000111;
  localparam logic [9:0] O_WFIRST  = 10'b0000001100;
  localparam logic [9:0] O_WFRST_E = 10'b0000001101;
  localparam logic [9:0] O_WAIT_E  = 10'b0000000001;
  localparam logic [9:0] O_TIMEOUT = 10'b1101110101;

  typedef struct packed {
    logic [9:0]  outs;
    logic [15:0] st;
    logic [15:0] fl;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       imem_busywait, dmem_busywait;
  logic [4:0] id_rs1, id_rs2, ex_write_addr;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_reg_write_en;
  logic       ex_branch_taken, ex_is_muldiv, muldiv_done;
  logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic       exmem_en, exmem_flush, memwb_en, muldiv_start, muldiv_err;
  logic [15:0] stall_cnt, flush_cnt;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  pipeline_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .imem_busywait(imem_busywait), .dmem_busywait(dmem_busywait),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_write_addr(ex_write_addr), .ex_mem_read(ex_mem_read),
    .ex_reg_write_en(ex_reg_write_en), .ex_branch_taken(ex_branch_taken),
    .ex_is_muldiv(ex_is_muldiv), .muldiv_done(muldiv_done),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush),
    .exmem_en(exmem_en), .exmem_flush(exmem_flush), .memwb_en(memwb_en),
    .muldiv_start(muldiv_start), .muldiv_err(muldiv_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic idle();
    imem_busywait = 1'b0; dmem_busywait = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_write_addr = 5'd0; ex_mem_read = 1'b0; ex_reg_write_en = 1'b0;
    ex_branch_taken = 1'b0; ex_is_muldiv = 1'b0; muldiv_done = 1'b0;
  endtask

  task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2);
    ex_mem_read = 1'b1; ex_reg_write_en = 1'b1; ex_write_addr = rd;
    id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
  endtask

  // Inputs are already applied; queue the expectation and advance one cycle
  task automatic step(input string nm, input logic [9:0] o, input int st, input int fl);
    exp_t e;
    e.outs = o;
    e.st   = 16'(st);
    e.fl   = 16'(fl);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the live outputs against the oldest queued expectation
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      logic [9:0] got;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
             exmem_en, exmem_flush, memwb_en, muldiv_start, muldiv_err};
      n_checks += 3;
      if (got !== e.outs) begin
        n_fail++;
        $display("FAIL %s outs: got %b expected %b", nm, got, e.outs);
      end
      if (stall_cnt !== e.st) begin
        n_fail++;
        $display("FAIL %s stall_cnt: got %0d expected %0d", nm, stall_cnt, e.st);
      end
      if (flush_cnt !== e.fl) begin
        n_fail++;
        $display("FAIL %s flush_cnt: got %0d expected %0d", nm, flush_cnt, e.fl);
      end
    end
  end

  initial begin
    reset = 1'b0;
    idle();
    @(posedge clk);
    #1;
    step("reset_hold", O_FREEZE, 0, 0);
    reset = 1'b1;
    step("post_reset", O_ALL, 0, 0);

    // Load-use on rs1, rd=0 suppression, rs2 match, unused rs2
    load_use(5'd5, 5'd5, 5'd0, 1'b1, 1'b0); step("lu_rs1", O_LOADUSE, 0, 0);
    idle();                                 step("lu_rs1_after", O_ALL, 1, 0);
    load_use(5'd0, 5'd0, 5'd0, 1'b1, 1'b0); step("lu_x0", O_ALL, 1, 0);
    load_use(5'd7, 5'd1, 5'd7, 1'b1, 1'b1); step("lu_rs2", O_LOADUSE, 1, 0);
    load_use(5'd7, 5'd1, 5'd7, 1'b1, 1'b0); step("lu_rs2_unused", O_ALL, 2, 0);

    // Branch alone, then branch colliding with a load-use match
    idle(); ex_branch_taken = 1'b1;         step("branch", O_BRANCH, 2, 0);
    idle();                                 step("branch_after", O_ALL, 2, 1);
    load_use(5'd9, 5'd9, 5'd0, 1'b1, 1'b0);
    ex_branch_taken = 1'b1;                 step("branch_vs_lu", O_BRANCH, 2, 1);
    idle(); imem_busywait = 1'b1;           step("imem_freeze", O_FREEZE, 2, 2);
    idle();                                 step("freeze_after", O_ALL, 3, 2);

    // MUL/DIV with done after eight wait cycles: PC frozen nine cycles
    ex_is_muldiv = 1'b1;                    step("md_start", O_MSTART, 3, 2);
    step("md_wait_first", O_WFIRST, 4, 2);
    for (int k = 1; k <= 7; k++) step("md_wait", O_FREEZE, 4 + k, 2);
    muldiv_done = 1'b1;                     step("md_done", O_ALL, 12, 2);
    idle();                                 step("md_after", O_ALL, 12, 2);

    // Done pulse while dmem is busy; advance only on release
    ex_is_muldiv = 1'b1;                    step("mdb_start", O_MSTART, 12, 2);
    step("mdb_wait_first", O_WFIRST, 13, 2);
    dmem_busywait = 1'b1; muldiv_done = 1'b1; step("mdb_done_busy", O_FREEZE, 14, 2);
    muldiv_done = 1'b0;                     step("mdb_busy2", O_FREEZE, 15, 2);
    step("mdb_busy3", O_FREEZE, 16, 2);
    dmem_busywait = 1'b0;                   step("mdb_release", O_ALL, 17, 2);
    // Back-to-back M op is started fresh
    step("b2b_start", O_MSTART, 17, 2);
    step("b2b_wait_first", O_WFIRST, 18, 2);
    muldiv_done = 1'b1;                     step("b2b_done", O_ALL, 19, 2);
    idle();                                 step("b2b_after", O_ALL, 19, 2);

    // Timeout on the fortieth wait cycle, error stays sticky
    ex_is_muldiv = 1'b1;                    step("to_start", O_MSTART, 19, 2);
    step("to_wait_first", O_WFIRST, 20, 2);
    for (int k = 1; k <= 38; k++) step("to_wait", O_FREEZE, 20 + k, 2);
    step("to_expire", O_TIMEOUT, 59, 2);
    idle();                                 step("to_sticky", O_ALL_E, 59, 2);
    ex_branch_taken = 1'b1;                 step("to_branch", O_BR_E, 59, 2);
    idle();                                 step("to_sticky2", O_ALL_E, 59, 3);

    // Async reset dropped between edges in the middle of a wait
    ex_is_muldiv = 1'b1;                    step("rst_start", O_MSTRT_E, 59, 3);
    step("rst_wait_first", O_WFRST_E, 60, 3);
    step("rst_wait", O_WAIT_E, 61, 3);
    reset = 1'b0;                           step("rst_async", O_FREEZE, 0, 0);
    reset = 1'b1; idle();                   step("rst_release", O_ALL, 0, 0);
    step("rst_idle", O_ALL, 0, 0);

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
